// File: rtl/mmu_pkg.sv
// Shared types and constants for the MMU memory-side AXI4-Lite bridge.
package mmu_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORD_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        RESP,
        AW_W,
        B
    } bridge_state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [3:0] WSTRB_FULL    = 4'hF;

    // Write-back queue entry: word address plus data.
    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // Word address to byte-aligned AXI address.
    function automatic logic [ADDR_W-1:0] word_to_byte(input logic [WORD_W-1:0] w);
        return {w, 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head and registered empty/full flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        count_n = count;
        case ({do_push, do_pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
    end

    // Storage array; contents are don't-care while the slot is empty.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_n;
            empty <= (count_n == '0);
            full  <= (count_n == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/mmu_axi_bridge.sv
// Queues cache fills and write-backs and serialises them onto one AXI4-Lite master port.
module mmu_axi_bridge
    import mmu_pkg::*;
#(
    parameter int unsigned RD_DEPTH = 4,
    parameter int unsigned WR_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              rd_rq,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_valid_addr,
    input  logic              rd_valid_ack,
    input  logic              wr_rq,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_full,
    output logic              wr_full,
    output logic              err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    bridge_state_t     state;
    logic [WORD_W-1:0] rd_head;
    logic              rd_empty;
    logic              rd_pop_c;
    logic              rd_drop_c;
    wr_entry_t         wr_head;
    wr_entry_t         wr_push_entry;
    logic              wr_empty;
    logic              wr_pop_c;
    logic              wr_drop_c;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{rd_addr[1:0], wr_addr[1:0]};

    assign wr_push_entry = '{addr: wr_addr[ADDR_W-1:2], data: wr_data};
    assign rd_pop_c      = (state == RESP) && rd_valid_ack;
    assign wr_pop_c      = (state == B) && bvalid;
    assign rd_drop_c     = rd_rq && rd_full;
    assign wr_drop_c     = wr_rq && wr_full;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (RD_DEPTH)
    ) u_rd_q (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .push      (rd_rq),
        .push_data (rd_addr[ADDR_W-1:2]),
        .pop       (rd_pop_c),
        .head      (rd_head),
        .empty     (rd_empty),
        .full      (rd_full)
    );

    sync_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (WR_DEPTH)
    ) u_wr_q (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .push      (wr_rq),
        .push_data (wr_push_entry),
        .pop       (wr_pop_c),
        .head      (wr_head),
        .empty     (wr_empty),
        .full      (wr_full)
    );

    // Transaction sequencer; write-backs win arbitration so fills never overtake them.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= IDLE;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            rd_valid_addr <= '0;
            err           <= 1'b0;
            araddr        <= '0;
            arvalid       <= 1'b0;
            rready        <= 1'b0;
            awaddr        <= '0;
            awvalid       <= 1'b0;
            wdata         <= '0;
            wstrb         <= '0;
            wvalid        <= 1'b0;
            bready        <= 1'b0;
        end else begin
            wstrb <= WSTRB_FULL;
            if (rd_drop_c || wr_drop_c) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!wr_empty) begin
                        awaddr  <= word_to_byte(wr_head.addr);
                        wdata   <= wr_head.data;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        state   <= AW_W;
                    end else if (!rd_empty) begin
                        araddr  <= word_to_byte(rd_head);
                        arvalid <= 1'b1;
                        state   <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready        <= 1'b0;
                        rd_data       <= rdata;
                        rd_valid_addr <= araddr;
                        rd_valid      <= 1'b1;
                        if (rresp != AXI_RESP_OKAY) err <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rd_valid_ack) begin
                        rd_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                AW_W: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (bresp != AXI_RESP_OKAY) err <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
